multdiv_sequencer: RTL and testbench
====================================

MULTDIV_SEQUENCER -- requirements
Module: multdiv_sequencer

Interface
REQ-001 Parameter MAX_CYCLES, default 40, SHALL be the watchdog limit in WAIT cycles before a forced exception.
REQ-002 Parameter MUL_EXC_CODE, default 4, SHALL be the rstatus value written on multiply exception.
REQ-003 Parameter DIV_EXC_CODE, default 5, SHALL be the rstatus value written on divide exception or watchdog expiry during a divide.
REQ-004 clock  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 ex_valid  in  1  execute stage holds a valid instruction.
REQ-007 is_mult, is_div  in  1 each  decoded mul/div flags for the execute instruction.
REQ-008 op_a, op_b  in  32  operand values selected in execute.
REQ-009 rd  in  5  destination register of the execute instruction.
REQ-010 abort  in  1  squash the in-flight operation.
REQ-011 unit_result  in  32, unit_ready  in  1, unit_exception  in  1  outputs of the iterative mult/div unit.
REQ-012 unit_mult, unit_div  out  1 each  one-cycle start pulses to the unit.
REQ-013 unit_a, unit_b  out  32  latched operands to the unit.
REQ-014 stall  out  1  freeze fetch/decode/execute.
REQ-015 busy  out  1  FSM not in IDLE.
REQ-016 wb_valid  out  1, wb_reg  out  5, wb_data  out  32  register-file write request.

Function
REQ-017 FSM states SHALL be IDLE, START, WAIT, WB.
REQ-018 IDLE: when ex_valid and (is_mult or is_div), the block SHALL latch op_a, op_b, rd, op type; go to START; assert stall combinationally in that cycle.
REQ-019 If is_mult and is_div are both high, multiply SHALL take priority.
REQ-020 START: exactly one of unit_mult/unit_div SHALL be high for one cycle; the watchdog counter SHALL clear; next state WAIT.
REQ-021 WAIT: the counter SHALL increment each cycle; on unit_ready the block SHALL capture unit_result and unit_exception and go to WB.
REQ-022 WAIT: if the counter reaches MAX_CYCLES-1 without unit_ready, the block SHALL go to WB with exception forced to 1.
REQ-023 WB: wb_valid SHALL be high for exactly one cycle; on exception wb_reg=30 and wb_data=MUL_EXC_CODE or DIV_EXC_CODE per op type; otherwise wb_reg=latched rd and wb_data=captured result.
REQ-024 WB with no exception and rd=0 SHALL suppress wb_valid.
REQ-025 stall SHALL be high in START and WAIT, and low in WB; WB SHALL return to IDLE unconditionally, so the same instruction is never relaunched.
REQ-026 Latency: request in cycle 0, start pulse in cycle 1, unit_ready in cycle k, and wb_valid in cycle k+1.
REQ-027 unit_ready or unit_exception in IDLE, START or WB SHALL be ignored.
REQ-028 abort in any state SHALL force IDLE on the next edge, with no wb_valid, and stall low from that edge on; abort in IDLE SHALL block acceptance that cycle.
REQ-029 unit_a/unit_b SHALL hold latched values from START until the next accepted request.

Reset
REQ-030 On reset low the block SHALL asynchronously enter IDLE with all outputs 0, counter 0, and latches 0.
REQ-031 Reset asserted mid-operation SHALL discard the operation without a write-back.

Structure
REQ-032 A shared package SHALL hold the state enum, exception codes 4/5, and the rstatus register index 30.
REQ-033 The watchdog counter SHALL be one sub-module, multdiv_watchdog, with clear/enable/expired ports.

Verification
REQ-034 mult 7*6, rd=3, unit_ready at cycle 18 -> start pulse cycle 1, stall cycles 0-17, wb r3=42 in cycle 19.
REQ-035 div 100/0, rd=4, unit_ready and unit_exception -> wb r30=5, no write to r4.
REQ-036 mult, rd=0, no exception -> no wb_valid; with exception -> wb r30=4.
REQ-037 div, unit_ready never asserted, MAX_CYCLES=40 -> wb r30=5 in cycle 41 and stall released.
REQ-038 abort in WAIT cycle 10, then a later unit_ready -> IDLE, no wb, ready ignored; new mult accepted next cycle.
REQ-039 reset low during WAIT -> all outputs 0 asynchronously; after release, no wb, and the next request is accepted normally.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the mul/div sequencer: FSM states,
// default exception codes and the rstatus register index.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    WB
  } stateE;

  localparam logic [31:0] MUL_EXC_DEFAULT = 32'd4;
  localparam logic [31:0] DIV_EXC_DEFAULT = 32'd5;
  localparam logic [4:0]  RSTATUS_REG     = 5'd30;

endpackage

// File: rtl/multdiv_watchdog.sv
// Cycle counter bounding how long the sequencer waits on the iterative unit.
// expired fires in the enabled cycle whose increment brings the count to MAX_CYCLES-1.
module multdiv_watchdog #(
  parameter int MAX_CYCLES = 40
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(MAX_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(MAX_CYCLES - 2);

  logic [CW-1:0] countQ;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      countQ <= '0;
    end else if (clear) begin
      countQ <= '0;
    end else if (enable) begin
      countQ <= countQ + CW'(1);
    end
  end

  assign expired = enable && (countQ == LAST);

endmodule

// File: rtl/multdiv_sequencer.sv
// Launches multi-cycle multiply/divide operations on an iterative unit,
// stalls the pipeline while it runs, and issues the register-file write-back.
module multdiv_sequencer
  import multdiv_pkg::*;
#(
  parameter int          MAX_CYCLES   = 40,
  parameter logic [31:0] MUL_EXC_CODE = MUL_EXC_DEFAULT,
  parameter logic [31:0] DIV_EXC_CODE = DIV_EXC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        is_mult,
  input  logic        is_div,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  rd,
  input  logic        abort,
  input  logic [31:0] unit_result,
  input  logic        unit_ready,
  input  logic        unit_exception,
  output logic        unit_mult,
  output logic        unit_div,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic        stall,
  output logic        busy,
  output logic        wb_valid,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data
);

  stateE       stateQ, stateD;
  logic [31:0] opAQ, opBQ, resultQ;
  logic [4:0]  rdQ;
  logic        isMulQ, excQ;
  logic        accept, capture, timeout;
  logic        wdClear, wdEnable, wdExpired;

  multdiv_watchdog #(.MAX_CYCLES(MAX_CYCLES)) watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (wdClear),
    .enable (wdEnable),
    .expired(wdExpired)
  );

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    stateD    = stateQ;
    accept    = 1'b0;
    capture   = 1'b0;
    timeout   = 1'b0;
    wdClear   = 1'b0;
    wdEnable  = 1'b0;
    stall     = 1'b0;
    unit_mult = 1'b0;
    unit_div  = 1'b0;
    wb_valid  = 1'b0;
    wb_reg    = '0;
    wb_data   = '0;
    case (stateQ)
      IDLE: begin
        if (ex_valid && (is_mult || is_div) && !abort) begin
          accept = 1'b1;
          stall  = 1'b1;
          stateD = START;
        end
      end
      START: begin
        unit_mult = isMulQ && !abort;
        unit_div  = !isMulQ && !abort;
        wdClear   = 1'b1;
        stall     = !abort;
        stateD    = WAIT;
      end
      WAIT: begin
        wdEnable = 1'b1;
        if (unit_ready) begin
          capture = 1'b1;
          stateD  = WB;
        end else if (wdExpired) begin
          timeout = 1'b1;
          stateD  = WB;
        end
        // Release the pipeline as soon as the outcome is known.
        stall = !(unit_ready || wdExpired) && !abort;
      end
      WB: begin
        stateD = IDLE;
        if (excQ) begin
          wb_valid = !abort;
          wb_reg   = RSTATUS_REG;
          wb_data  = isMulQ ? MUL_EXC_CODE : DIV_EXC_CODE;
        end else begin
          wb_valid = (rdQ != 5'd0) && !abort;
          wb_reg   = rdQ;
          wb_data  = resultQ;
        end
      end
      default: stateD = IDLE;
    endcase
    if (abort) stateD = IDLE;
  end

  // NOTE: the operand/result registers are plain flops, not a memory, so they
  // take the async reset and come up as zero on the unit_a/unit_b ports.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stateQ  <= IDLE;
      opAQ    <= '0;
      opBQ    <= '0;
      rdQ     <= '0;
      isMulQ  <= 1'b0;
      resultQ <= '0;
      excQ    <= 1'b0;
    end else begin
      stateQ <= stateD;
      if (accept) begin
        opAQ   <= op_a;
        opBQ   <= op_b;
        rdQ    <= rd;
        isMulQ <= is_mult;
      end
      if (capture) begin
        resultQ <= unit_result;
        excQ    <= unit_exception;
      end else if (timeout) begin
        excQ <= 1'b1;
      end
    end
  end

  assign busy   = (stateQ != IDLE);
  assign unit_a = opAQ;
  assign unit_b = opBQ;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench: directed spec scenarios plus randomized operations
// checked cycle by cycle against a transaction-level timing model.
module tb_multdiv_sequencer;

  localparam int MAX = 40;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_valid, is_mult, is_div, abort;
  logic [31:0] op_a, op_b, unit_result;
  logic [4:0]  rd;
  logic        unit_ready, unit_exception;
  logic        unit_mult, unit_div, stall, busy, wb_valid;
  logic [31:0] unit_a, unit_b, wb_data;
  logic [4:0]  wb_reg;

  int checks = 0;
  int passed = 0;

  always #5 clock = ~clock;

  multdiv_sequencer #(
    .MAX_CYCLES  (MAX),
    .MUL_EXC_CODE(32'd4),
    .DIV_EXC_CODE(32'd5)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .ex_valid      (ex_valid),
    .is_mult       (is_mult),
    .is_div        (is_div),
    .op_a          (op_a),
    .op_b          (op_b),
    .rd            (rd),
    .abort         (abort),
    .unit_result   (unit_result),
    .unit_ready    (unit_ready),
    .unit_exception(unit_exception),
    .unit_mult     (unit_mult),
    .unit_div      (unit_div),
    .unit_a        (unit_a),
    .unit_b        (unit_b),
    .stall         (stall),
    .busy          (busy),
    .wb_valid      (wb_valid),
    .wb_reg        (wb_reg),
    .wb_data       (wb_data)
  );

  task automatic clear_inputs();
    ex_valid = 0; is_mult = 0; is_div = 0; abort = 0;
    op_a = '0; op_b = '0; rd = '0;
    unit_result = '0; unit_ready = 0; unit_exception = 0;
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({unit_mult, unit_div, stall, busy, wb_valid} !== 5'b0 ||
        unit_a !== 32'd0 || unit_b !== 32'd0 || wb_reg !== 5'd0 || wb_data !== 32'd0)
      $display("FAIL %s outputs got mult=%b div=%b stall=%b busy=%b wbv=%b a=%h b=%h reg=%0d data=%h, want all zero",
               name, unit_mult, unit_div, stall, busy, wb_valid, unit_a, unit_b, wb_reg, wb_data);
    else passed++;
  endtask

  // One request issued in the current cycle (called just after a rising edge).
  // readyAt/strayAt are cycle offsets from the request; -1 means never.
  // Model: a ready counts only in WAIT cycles 2..MAX, otherwise the watchdog
  // ends the operation with a write-back in cycle MAX+1.
  task automatic run_op(input string name, input bit m, input bit d,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] r,
                        input int readyAt, input bit exc, input logic [31:0] res,
                        input int strayAt);
    bit          inWait   = (readyAt >= 2) && (readyAt <= MAX);
    int          wbC      = inWait ? readyAt + 1 : MAX + 1;
    bit          excExp   = !inWait || exc;
    bit          isMul    = m;
    bit          validExp = excExp || (r != 5'd0);
    logic [4:0]  regExp   = excExp ? 5'd30 : r;
    logic [31:0] dataExp  = excExp ? (isMul ? 32'd4 : 32'd5) : res;
    for (int c = 0; c <= wbC + 1; c++) begin
      ex_valid       = (c == 0);
      is_mult        = (c == 0) && m;
      is_div         = (c == 0) && d;
      op_a           = (c == 0) ? a : 32'h0BAD_0BAD;
      op_b           = (c == 0) ? b : 32'h0BAD_0BAD;
      rd             = (c == 0) ? r : 5'd31;
      unit_ready     = (c == readyAt) || (c == strayAt);
      unit_exception = (c == readyAt) ? exc : (c == strayAt);
      unit_result    = (c == readyAt) ? res : 32'hDEAD_BEEF;
      @(negedge clock);
      checks++;
      if (stall !== (c < wbC - 1))
        $display("FAIL %s c%0d stall got %b want %b", name, c, stall, c < wbC - 1);
      else passed++;
      checks++;
      if (busy !== (c >= 1 && c <= wbC))
        $display("FAIL %s c%0d busy got %b want %b", name, c, busy, c >= 1 && c <= wbC);
      else passed++;
      checks++;
      if (unit_mult !== (c == 1 && isMul) || unit_div !== (c == 1 && !isMul))
        $display("FAIL %s c%0d start got mult=%b div=%b want mult=%b div=%b",
                 name, c, unit_mult, unit_div, c == 1 && isMul, c == 1 && !isMul);
      else passed++;
      checks++;
      if (wb_valid !== (c == wbC && validExp))
        $display("FAIL %s c%0d wb_valid got %b want %b", name, c, wb_valid, c == wbC && validExp);
      else passed++;
      if (c == wbC && validExp) begin
        checks++;
        if (wb_reg !== regExp || wb_data !== dataExp)
          $display("FAIL %s c%0d writeback got r%0d=%h want r%0d=%h",
                   name, c, wb_reg, wb_data, regExp, dataExp);
        else passed++;
      end
      if (c >= 1 && c <= wbC) begin
        checks++;
        if (unit_a !== a || unit_b !== b)
          $display("FAIL %s c%0d operands got %h,%h want %h,%h", name, c, unit_a, unit_b, a, b);
        else passed++;
      end
      @(posedge clock); #1;
    end
    clear_inputs();
  endtask

  task automatic test_reset();
    check_all_zero("reset");
  endtask

  task automatic test_mult_basic();
    run_op("mult7x6", 1, 0, 32'd7, 32'd6, 5'd3, 18, 0, 32'd42, -1);
  endtask

  task automatic test_div_exception();
    run_op("div_by_zero", 0, 1, 32'd100, 32'd0, 5'd4, 9, 1, 32'h1234_5678, -1);
  endtask

  task automatic test_rd_zero();
    run_op("mult_rd0", 1, 0, 32'd3, 32'd5, 5'd0, 6, 0, 32'd15, -1);
    run_op("mult_rd0_exc", 1, 0, 32'd3, 32'd5, 5'd0, 6, 1, 32'd15, -1);
  endtask

  task automatic test_priority();
    run_op("both_flags", 1, 1, 32'hFFFF_FFFF, 32'd2, 5'd9, 4, 1, 32'd0, -1);
  endtask

  task automatic test_timeout();
    run_op("watchdog", 0, 1, 32'd81, 32'd9, 5'd7, -1, 0, 32'd9, -1);
    run_op("ready_last", 1, 0, 32'd11, 32'd12, 5'd8, MAX, 0, 32'd132, -1);
  endtask

  task automatic test_abort();
    // Abort in IDLE blocks acceptance.
    ex_valid = 1; is_mult = 1; abort = 1; op_a = 32'd1; op_b = 32'd2; rd = 5'd5;
    @(negedge clock);
    checks++;
    if (stall !== 1'b0) $display("FAIL abort_idle stall got %b want 0", stall);
    else passed++;
    @(posedge clock); #1;
    clear_inputs();
    checks++;
    if (busy !== 1'b0) $display("FAIL abort_idle busy got %b want 0", busy);
    else passed++;
    // Divide aborted in WAIT cycle 10.
    ex_valid = 1; is_div = 1; op_a = 32'd100; op_b = 32'd7; rd = 5'd6;
    @(posedge clock); #1;
    clear_inputs();
    for (int c = 1; c < 10; c++) begin
      @(posedge clock); #1;
    end
    abort = 1;
    @(negedge clock);
    checks++;
    if (stall !== 1'b0 || wb_valid !== 1'b0)
      $display("FAIL abort_wait stall/wb got %b/%b want 0/0", stall, wb_valid);
    else passed++;
    @(posedge clock); #1;
    abort = 0;
    checks++;
    if (busy !== 1'b0 || stall !== 1'b0 || wb_valid !== 1'b0)
      $display("FAIL abort_idle_after busy/stall/wb got %b/%b/%b want 0/0/0", busy, stall, wb_valid);
    else passed++;
    // New mult next cycle; the late ready from the aborted divide lands in START.
    run_op("after_abort", 1, 0, 32'd21, 32'd2, 5'd12, 5, 0, 32'd42, 1);
  endtask

  task automatic test_reset_mid_op();
    ex_valid = 1; is_mult = 1; op_a = 32'd9; op_b = 32'd9; rd = 5'd10;
    @(posedge clock); #1;
    clear_inputs();
    for (int c = 1; c < 5; c++) begin
      @(posedge clock); #1;
    end
    @(negedge clock);
    reset = 0;
    #1;
    check_all_zero("reset_mid_wait");
    @(posedge clock); #1;
    reset = 1;
    for (int c = 0; c < 3; c++) begin
      unit_ready = 1; unit_exception = 1; unit_result = 32'd81;
      @(negedge clock);
      checks++;
      if (wb_valid !== 1'b0 || busy !== 1'b0)
        $display("FAIL post_reset c%0d wb_valid/busy got %b/%b want 0/0", c, wb_valid, busy);
      else passed++;
      @(posedge clock); #1;
    end
    clear_inputs();
    run_op("after_reset", 0, 1, 32'd50, 32'd5, 5'd11, 12, 0, 32'd10, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      bit          m   = 1'($urandom_range(0, 1));
      bit          d   = m ? 1'($urandom_range(0, 1)) : 1'b1;
      logic [31:0] a   = $urandom;
      logic [31:0] b   = $urandom;
      logic [4:0]  r   = 5'($urandom_range(0, 31));
      int          rdy = $urandom_range(0, MAX + 3);
      bit          exc = ($urandom_range(0, 3) == 0);
      int          str = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 1));
      logic [31:0] res = m ? a * b : (b != 0 ? a / b : 32'hFFFF_FFFF);
      run_op($sformatf("random%0d", i), m, d, a, b, r, rdy, exc, res, str);
    end
  endtask

  initial begin
    reset = 0;
    clear_inputs();
    #2;
    test_reset();
    #10 reset = 1;
    @(posedge clock); #1;
    test_mult_basic();
    test_div_exception();
    test_rd_zero();
    test_priority();
    test_timeout();
    test_abort();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
